// File: rtl/machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, staged 64-bit mtimecmp,
// level-sensitive timer interrupt, single-cycle peripheral bus slave.
module machine_timer #(
  parameter int               INT_W     = 8,
  parameter logic [INT_W-1:0] INT_TIMER = 8'h01,
  parameter int               PRESC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [4:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             ack_o,
  output logic [INT_W-1:0] int_flag_o
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_PRESC    = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;

  localparam logic [PRESC_W-1:0] P_ONE = 1;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [31:0]        cmp_lo_stage;
  logic [31:0]        hi_shadow;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               cnt_en;
  logic               irq_en;
  logic               pending;
  logic [2:0]         sel;
  logic [31:0]        rd_mux;
  logic               unused_addr;

  assign sel         = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    rd_mux = '0;
    case (sel)
      A_MTIME_LO: rd_mux = mtime[31:0];
      A_MTIME_HI: rd_mux = hi_shadow;
      A_CMP_LO:   rd_mux = mtimecmp[31:0];
      A_CMP_HI:   rd_mux = mtimecmp[63:32];
      A_CTRL:     rd_mux = {30'd0, irq_en, cnt_en};
      A_PRESC:    rd_mux = 32'(presc);
      A_STATUS:   rd_mux = {31'd0, pending};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime        <= '0;
      mtimecmp     <= '1;
      cmp_lo_stage <= '0;
      hi_shadow    <= '0;
      presc        <= '0;
      presc_cnt    <= '0;
      cnt_en       <= 1'b0;
      irq_en       <= 1'b0;
      pending      <= 1'b0;
      rdata_o      <= '0;
      ack_o        <= 1'b0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= '0;
      pending <= (mtime >= mtimecmp);

      if (cnt_en) begin
        if (presc_cnt == presc) begin
          presc_cnt <= '0;
          mtime     <= mtime + 64'd1;
        end else begin
          presc_cnt <= presc_cnt + P_ONE;
        end
      end

      // Bus writes are assigned last so they override a same-cycle tick.
      if (req_i && we_i) begin
        case (sel)
          A_MTIME_LO: begin
            mtime     <= {mtime[63:32], wdata_i};
            presc_cnt <= '0;
          end
          A_MTIME_HI: begin
            mtime     <= {wdata_i, mtime[31:0]};
            presc_cnt <= '0;
          end
          A_CMP_LO: cmp_lo_stage <= wdata_i;
          A_CMP_HI: mtimecmp     <= {wdata_i, cmp_lo_stage};
          A_CTRL: begin
            irq_en <= wdata_i[1];
            cnt_en <= wdata_i[0];
          end
          A_PRESC: begin
            presc     <= wdata_i[PRESC_W-1:0];
            presc_cnt <= '0;
          end
          default: ;
        endcase
      end else if (req_i) begin
        rdata_o <= rd_mux;
        if (sel == A_MTIME_LO)
          hi_shadow <= mtime[63:32];
      end
    end
  end

  assign int_flag_o = (pending && irq_en) ? INT_TIMER : '0;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: bus timing, prescaler, wrap,
// shadowed high read, compare/interrupt and reset behaviour.
module tb_machine_timer;

  localparam logic [4:0] MT_LO  = 5'h00;
  localparam logic [4:0] MT_HI  = 5'h04;
  localparam logic [4:0] C_LO   = 5'h08;
  localparam logic [4:0] C_HI   = 5'h0C;
  localparam logic [4:0] CTRL   = 5'h10;
  localparam logic [4:0] PRESC  = 5'h14;
  localparam logic [4:0] STATUS = 5'h18;
  localparam logic [4:0] UNMAP  = 5'h1C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic [7:0]  int_flag;

  int vectors = 0;
  int miscompares = 0;

  machine_timer dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .ack_o      (ack),
    .int_flag_o (int_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [4:0] a,
                        input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    check("ack", {63'd0, ack}, 64'd1);
    r = rdata;
  endtask

  logic [31:0] r, ra, rb, diff;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_flag", {56'd0, int_flag}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk) rst = 1'b0;
    access(1'b0, STATUS, 0, r); check("rst_status", {32'd0, r}, 64'd0);
    access(1'b0, C_HI, 0, r);   check("rst_cmp_hi", {32'd0, r}, 64'hFFFF_FFFF);
    access(1'b0, MT_HI, 0, r);  check("rst_shadow", {32'd0, r}, 64'd0);
    @(posedge clk); #1;
    check("ack_drop", {63'd0, ack}, 64'd0);
    check("rdata_idle", {32'd0, rdata}, 64'd0);

    // prescaler: period of 4 cycles
    access(1'b1, PRESC, 32'd3, r);
    access(1'b1, CTRL, 32'd1, r);
    access(1'b0, MT_LO, 0, ra);
    repeat (39) @(posedge clk);
    access(1'b0, MT_LO, 0, rb);
    diff = rb - ra;
    check("presc_delta", {32'd0, diff}, 64'd10);

    // wrap and shadowed high half
    access(1'b1, CTRL, 32'd0, r);
    access(1'b1, PRESC, 32'd0, r);
    access(1'b1, MT_LO, 32'hFFFF_FFFE, r);
    access(1'b1, MT_HI, 32'hFFFF_FFFF, r);
    access(1'b1, CTRL, 32'd1, r);
    access(1'b0, MT_LO, 0, r); check("wrap_lo0", {32'd0, r}, 64'hFFFF_FFFE);
    access(1'b0, MT_LO, 0, r); check("wrap_lo1", {32'd0, r}, 64'hFFFF_FFFF);
    access(1'b0, MT_HI, 0, r); check("shadow_hi", {32'd0, r}, 64'hFFFF_FFFF);
    access(1'b0, MT_LO, 0, r); check("wrap_lo2", {32'd0, r}, 64'd1);
    access(1'b0, MT_HI, 0, r); check("wrap_hi", {32'd0, r}, 64'd0);

    // compare at 0x64 with interrupt enabled
    access(1'b1, CTRL, 32'd0, r);
    access(1'b1, MT_LO, 32'd0, r);
    access(1'b1, MT_HI, 32'd0, r);
    access(1'b1, C_LO, 32'h64, r);
    access(1'b1, C_HI, 32'd0, r);
    access(1'b1, CTRL, 32'd3, r);
    repeat (99) @(posedge clk); #1;
    check("irq_early", {56'd0, int_flag}, 64'd0);
    @(posedge clk); #1;
    check("irq_at_match", {56'd0, int_flag}, 64'd0);
    @(posedge clk); #1;
    check("irq_set", {56'd0, int_flag}, 64'h01);
    access(1'b0, STATUS, 0, r); check("status_set", {32'd0, r}, 64'd1);
    access(1'b1, C_HI, 32'd1, r);
    check("irq_hold", {56'd0, int_flag}, 64'h01);
    @(posedge clk); #1;
    check("irq_clear", {56'd0, int_flag}, 64'd0);

    // pending with irq disabled
    access(1'b1, C_LO, 32'h10, r);
    access(1'b1, C_HI, 32'd0, r);
    access(1'b1, CTRL, 32'd1, r);
    check("irq_masked", {56'd0, int_flag}, 64'd0);
    access(1'b0, STATUS, 0, r); check("status_raw", {32'd0, r}, 64'd1);

    // staged low compare half does not take effect alone
    access(1'b1, C_LO, 32'hFFFF_FFFF, r);
    access(1'b0, STATUS, 0, r); check("stage_pend", {32'd0, r}, 64'd1);
    access(1'b0, C_LO, 0, r);   check("cmp_lo_rd", {32'd0, r}, 64'h10);
    access(1'b0, CTRL, 0, r);   check("ctrl_rd", {32'd0, r}, 64'd1);
    access(1'b1, UNMAP, 32'hDEAD, r);
    access(1'b0, UNMAP, 0, r);  check("unmapped", {32'd0, r}, 64'd0);

    // reset during an in-flight request
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = CTRL;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_mid_ack", {63'd0, ack}, 64'd0);
    check("rst_mid_flag", {56'd0, int_flag}, 64'd0);
    @(negedge clk) rst = 1'b0;
    access(1'b0, CTRL, 0, r);  check("rst2_ctrl", {32'd0, r}, 64'd0);
    access(1'b0, C_HI, 0, r);  check("rst2_cmp", {32'd0, r}, 64'hFFFF_FFFF);
    access(1'b0, MT_LO, 0, r); check("rst2_mtime", {32'd0, r}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
